// File: rtl/beam_pkg.sv
// Frame geometry, FSM states, weight bundle and payload checksum shared by beam_weight_loader.
package beam_pkg;
   localparam int W_WIDTH      = 5;
   localparam int FRAME_BITS   = 24;
   localparam int PAYLOAD_BITS = 20;
   localparam int CSUM_BITS    = FRAME_BITS - PAYLOAD_BITS;

   typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

   // Field order matches the on-wire payload order, first field in the MSBs.
   typedef struct packed {
      logic signed [W_WIDTH-1:0] cos_1;
      logic signed [W_WIDTH-1:0] sin_1;
      logic signed [W_WIDTH-1:0] cos_2;
      logic signed [W_WIDTH-1:0] sin_2;
   } weights_t;

   function automatic logic [CSUM_BITS-1:0] checksum(input logic [PAYLOAD_BITS-1:0] payload);
      logic [CSUM_BITS-1:0] sum;
      sum = '0;
      for (int i = 0; i < PAYLOAD_BITS / CSUM_BITS; i++)
         sum = sum + payload[i*CSUM_BITS +: CSUM_BITS];
      return sum;
   endfunction
endpackage

// File: rtl/beam_weight_loader.sv
// Deserialises checksummed weight frames into a shadow register and commits them on apply.
// Result pulses one edge after the last bit; the serial side has no backpressure (ser_valid gaps stall).
module beam_weight_loader #(
   parameter int                        W_WIDTH    = 5,
   parameter bit                        AUTO_APPLY = 1'b0,
   parameter logic signed [W_WIDTH-1:0] COS_RST    = 5'sd15,
   parameter logic signed [W_WIDTH-1:0] SIN_RST    = 5'sd0
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      ser_valid,
   input  logic                      ser_start,
   input  logic                      ser_data,
   input  logic                      apply,
   output logic signed [W_WIDTH-1:0] w_cos_1,
   output logic signed [W_WIDTH-1:0] w_sin_1,
   output logic signed [W_WIDTH-1:0] w_cos_2,
   output logic signed [W_WIDTH-1:0] w_sin_2,
   output logic                      pending,
   output logic                      busy,
   output logic                      frame_ok,
   output logic                      frame_err
);
   import beam_pkg::*;

   localparam weights_t RST_W = '{cos_1: COS_RST, sin_1: SIN_RST, cos_2: COS_RST, sin_2: SIN_RST};
   localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

   state_t                 state_q, state_d;
   logic [FRAME_BITS-1:0]  frame_q;
   logic [4:0]             bit_cnt_q;
   weights_t               shadow_q, live_q, rx_w;
   logic                   take_start, take_bit, check_exit, sum_ok, commit;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      take_start = 1'b0;
      take_bit   = 1'b0;
      check_exit = 1'b0;
      case (state_q)
         IDLE: begin
            if (ser_valid && ser_start) begin
               take_start = 1'b1;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            // A new start mid-frame silently restarts capture from bit 0.
            if (ser_valid && ser_start) begin
               take_start = 1'b1;
            end else if (ser_valid) begin
               take_bit = 1'b1;
               if (bit_cnt_q == LAST_BIT) state_d = CHECK;
            end
         end
         CHECK: begin
            check_exit = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign rx_w   = weights_t'(frame_q[FRAME_BITS-1 -: PAYLOAD_BITS]);
   assign sum_ok = (checksum(frame_q[FRAME_BITS-1 -: PAYLOAD_BITS]) == frame_q[CSUM_BITS-1:0]);
   assign commit = check_exit && sum_ok;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         frame_q   <= '0;
         bit_cnt_q <= '0;
         shadow_q  <= RST_W;
         live_q    <= RST_W;
         pending   <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_ok  <= commit;
         frame_err <= check_exit && !sum_ok;
         if (take_start) begin
            frame_q   <= {{(FRAME_BITS-1){1'b0}}, ser_data};
            bit_cnt_q <= 5'd1;
         end else if (take_bit) begin
            frame_q   <= {frame_q[FRAME_BITS-2:0], ser_data};
            bit_cnt_q <= bit_cnt_q + 5'd1;
         end
         if (AUTO_APPLY) begin
            if (commit) begin
               live_q   <= rx_w;
               shadow_q <= rx_w;
            end
         end else begin
            // On a collision the live weights take the old shadow while the new frame becomes pending.
            if (apply && pending) live_q <= shadow_q;
            if (commit) begin
               shadow_q <= rx_w;
               pending  <= 1'b1;
            end else if (apply) begin
               pending  <= 1'b0;
            end
         end
      end
   end

   assign busy    = (state_q != IDLE);
   assign w_cos_1 = live_q.cos_1;
   assign w_sin_1 = live_q.sin_1;
   assign w_cos_2 = live_q.cos_2;
   assign w_sin_2 = live_q.sin_2;
endmodule

// File: tb/tb_beam_weight_loader.sv
// Scoreboard bench: one loader in apply mode and one in auto-apply mode share the serial stimulus.
module tb_beam_weight_loader;
   logic clock = 1'b0;
   logic reset, ser_valid, ser_start, ser_data, apply;
   logic signed [4:0] a_c1, a_s1, a_c2, a_s2, b_c1, b_s1, b_c2, b_s2;
   logic a_pend, a_busy, a_ok, a_err, b_pend, b_busy, b_ok, b_err;
   logic [19:0] wa, wb, last_a, last_b;

   always #5 clock = ~clock;

   assign wa = {a_c1, a_s1, a_c2, a_s2};
   assign wb = {b_c1, b_s1, b_c2, b_s2};

   beam_weight_loader #(.AUTO_APPLY(1'b0)) u_apply (
      .clock(clock), .reset(reset), .ser_valid(ser_valid), .ser_start(ser_start),
      .ser_data(ser_data), .apply(apply),
      .w_cos_1(a_c1), .w_sin_1(a_s1), .w_cos_2(a_c2), .w_sin_2(a_s2),
      .pending(a_pend), .busy(a_busy), .frame_ok(a_ok), .frame_err(a_err));

   beam_weight_loader #(.AUTO_APPLY(1'b1)) u_auto (
      .clock(clock), .reset(reset), .ser_valid(ser_valid), .ser_start(ser_start),
      .ser_data(ser_data), .apply(apply),
      .w_cos_1(b_c1), .w_sin_1(b_s1), .w_cos_2(b_c2), .w_sin_2(b_s2),
      .pending(b_pend), .busy(b_busy), .frame_ok(b_ok), .frame_err(b_err));

   typedef struct packed { logic ok; logic [19:0] w; logic pend; int cyc; } pulse_t;
   typedef struct packed { logic [19:0] w; logic pend; int cyc; } chg_t;

   pulse_t exp_pa[$], exp_pb[$];
   chg_t   exp_ca[$], exp_cb[$];
   pulse_t mp;
   chg_t   mc;
   int total = 0, bad = 0, cyc = 0;

   localparam logic [19:0] RST_W = {5'sd15, 5'sd0, 5'sd15, 5'sd0};
   logic [19:0] live_a, shadow_a, live_b;
   logic        pend_a;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic void chk(input string nm, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
      end
   endfunction

   // Reference checksum: sum of the five payload nibbles, reduced mod 16.
   function automatic logic [3:0] ref_csum(input logic [19:0] p);
      int s = 0;
      for (int k = 0; k < 5; k++) s += int'((p >> (4 * k)) & 20'hF);
      return 4'(s % 16);
   endfunction

   // Monitor: every result pulse and every change of live weights must match the head of its queue.
   always @(negedge clock) begin
      if (reset) begin
         last_a = wa;
         last_b = wb;
      end else begin
         chk("auto_pending_low", 32'(b_pend), 0);
         if (a_ok || a_err) begin
            if (exp_pa.size() == 0) begin
               total++; bad++;
               $display("FAIL pulse_a unexpected ok=%0b err=%0b required=no pulse", a_ok, a_err);
            end else begin
               mp = exp_pa.pop_front();
               chk("pulse_a_kind", 32'({a_ok, a_err}), 32'({mp.ok, ~mp.ok}));
               chk("pulse_a_cycle", cyc, mp.cyc);
               chk("pulse_a_pending", 32'(a_pend), 32'(mp.pend));
               chk("pulse_a_w", 32'(wa), 32'(mp.w));
               chk("pulse_a_busy", 32'(a_busy), 0);
            end
         end
         if (b_ok || b_err) begin
            if (exp_pb.size() == 0) begin
               total++; bad++;
               $display("FAIL pulse_b unexpected ok=%0b err=%0b required=no pulse", b_ok, b_err);
            end else begin
               mp = exp_pb.pop_front();
               chk("pulse_b_kind", 32'({b_ok, b_err}), 32'({mp.ok, ~mp.ok}));
               chk("pulse_b_cycle", cyc, mp.cyc);
               chk("pulse_b_w", 32'(wb), 32'(mp.w));
            end
         end
         if (wa != last_a) begin
            if (exp_ca.size() == 0) begin
               total++; bad++;
               $display("FAIL change_a unexpected w=%0h required=%0h", wa, last_a);
            end else begin
               mc = exp_ca.pop_front();
               chk("change_a_w", 32'(wa), 32'(mc.w));
               chk("change_a_cycle", cyc, mc.cyc);
               chk("change_a_pending", 32'(a_pend), 32'(mc.pend));
            end
         end
         if (wb != last_b) begin
            if (exp_cb.size() == 0) begin
               total++; bad++;
               $display("FAIL change_b unexpected w=%0h required=%0h", wb, last_b);
            end else begin
               mc = exp_cb.pop_front();
               chk("change_b_w", 32'(wb), 32'(mc.w));
               chk("change_b_cycle", cyc, mc.cyc);
            end
         end
         last_a = wa;
         last_b = wb;
      end
   end

   task automatic drive_bits(input logic [23:0] f, input int nbits, input int max_gap);
      for (int i = 0; i < nbits; i++) begin
         int g;
         g = (i == 0 || max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
         for (int k = 0; k < g; k++) begin
            @(negedge clock);
            ser_valid = 1'b0;
            ser_start = 1'($urandom);
            ser_data  = 1'($urandom);
         end
         @(negedge clock);
         ser_valid = 1'b1;
         ser_start = (i == 0);
         ser_data  = f[23 - i];
      end
   endtask

   task automatic send_frame(input logic [19:0] p, input logic [3:0] cs, input int max_gap,
                             input bit apply_exit);
      logic good, new_pend;
      drive_bits({p, cs}, 24, max_gap);
      @(negedge clock);
      ser_valid = 1'b0;
      ser_start = 1'b0;
      apply     = apply_exit;
      chk("busy_in_check", 32'(a_busy), 1);
      good     = (cs == ref_csum(p));
      new_pend = good ? 1'b1 : (apply_exit ? 1'b0 : pend_a);
      if (apply_exit && pend_a) begin
         if (shadow_a != live_a) exp_ca.push_back('{w: shadow_a, pend: new_pend, cyc: cyc + 1});
         live_a = shadow_a;
      end
      if (good) shadow_a = p;
      pend_a = new_pend;
      exp_pa.push_back('{ok: good, w: live_a, pend: pend_a, cyc: cyc + 1});
      if (good) begin
         if (p != live_b) exp_cb.push_back('{w: p, pend: 1'b0, cyc: cyc + 1});
         live_b = p;
      end
      exp_pb.push_back('{ok: good, w: live_b, pend: 1'b0, cyc: cyc + 1});
      @(negedge clock);
      apply = 1'b0;
      chk("frame_w_a", 32'(wa), 32'(live_a));
      chk("frame_pend_a", 32'(a_pend), 32'(pend_a));
      chk("frame_w_b", 32'(wb), 32'(live_b));
      @(negedge clock);
   endtask

   task automatic do_apply();
      @(negedge clock);
      apply = 1'b1;
      if (pend_a) begin
         if (shadow_a != live_a) exp_ca.push_back('{w: shadow_a, pend: 1'b0, cyc: cyc + 1});
         live_a = shadow_a;
         pend_a = 1'b0;
      end
      @(negedge clock);
      apply = 1'b0;
      chk("apply_w_a", 32'(wa), 32'(live_a));
      chk("apply_pend_a", 32'(a_pend), 32'(pend_a));
      chk("apply_w_b", 32'(wb), 32'(live_b));
   endtask

   initial begin
      logic [19:0] p, pa, pb;
      logic [3:0]  cs;
      reset = 1'b1; ser_valid = 1'b0; ser_start = 1'b0; ser_data = 1'b0; apply = 1'b0;
      live_a = RST_W; shadow_a = RST_W; live_b = RST_W; pend_a = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (10) @(negedge clock);
      chk("rst_cos_1", int'(a_c1), 15);
      chk("rst_sin_1", int'(a_s1), 0);
      chk("rst_cos_2", int'(a_c2), 15);
      chk("rst_sin_2", int'(a_s2), 0);
      chk("rst_flags_a", 32'({a_pend, a_busy, a_ok, a_err}), 0);
      chk("rst_flags_b", 32'({b_pend, b_busy, b_ok, b_err}), 0);
      chk("rst_w_b", 32'(wb), 32'(RST_W));

      // Worked example from the plan, then the same payload with a wrong checksum.
      p = 20'b01111_00000_10001_00011;
      send_frame(p, 4'b0110, 0, 1'b0);
      do_apply();
      chk("plan_cos_1", int'(a_c1), 15);
      chk("plan_sin_1", int'(a_s1), 0);
      chk("plan_cos_2", int'(a_c2), -15);
      chk("plan_sin_2", int'(a_s2), 3);
      send_frame(p, 4'b0111, 0, 1'b0);
      do_apply();

      // Stalled frame, then an aborted frame immediately restarted.
      p = 20'($urandom);
      send_frame(p, ref_csum(p), 3, 1'b0);
      do_apply();
      drive_bits({20'($urandom), 4'h0}, 10, 1);
      p = 20'($urandom);
      send_frame(p, ref_csum(p), 1, 1'b0);
      do_apply();

      // Apply lands on the edge that commits frame B while A is still pending.
      pa = 20'($urandom);
      pb = 20'($urandom);
      send_frame(pa, ref_csum(pa), 0, 1'b0);
      send_frame(pb, ref_csum(pb), 2, 1'b1);
      do_apply();

      for (int n = 0; n < 25; n++) begin
         p  = 20'($urandom);
         cs = ref_csum(p);
         if ($urandom_range(3, 0) == 0) cs = 4'((int'(cs) + int'($urandom_range(15, 1))) % 16);
         send_frame(p, cs, int'($urandom_range(2, 0)), ($urandom_range(3, 0) == 0));
         if ($urandom_range(1, 0) == 1) do_apply();
      end

      // Reset in the middle of a frame takes effect before the next edge.
      drive_bits(24'($urandom), 12, 0);
      chk("busy_mid_frame", 32'(a_busy), 1);
      @(posedge clock);
      #1 reset = 1'b1;
      #1;
      chk("arst_w_a", 32'(wa), 32'(RST_W));
      chk("arst_w_b", 32'(wb), 32'(RST_W));
      chk("arst_flags_a", 32'({a_pend, a_busy, a_ok, a_err}), 0);
      chk("arst_flags_b", 32'({b_pend, b_busy, b_ok, b_err}), 0);
      live_a = RST_W; shadow_a = RST_W; live_b = RST_W; pend_a = 1'b0;
      @(negedge clock);
      ser_valid = 1'b0;
      ser_start = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      p = 20'($urandom);
      send_frame(p, ref_csum(p), 1, 1'b0);
      do_apply();

      repeat (4) @(negedge clock);
      chk("leftover_pulse_a", exp_pa.size(), 0);
      chk("leftover_pulse_b", exp_pb.size(), 0);
      chk("leftover_change_a", exp_ca.size(), 0);
      chk("leftover_change_b", exp_cb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
